// File: rtl/spi_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_wb_pkg
// Purpose  : Shared types and constants for the SPI-to-Wishbone bridge:
//            protocol FSM states, command byte layout, overrun fill byte.
// Revision : 1.0  initial release
// ============================================================================
package spi_wb_pkg;

  // Frame decoder states: command, two address bytes, data, bus cycle
  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_BUS     = 3'd4
  } state_t;

  // Command byte layout: {rd, inc, addr[hi] field in [5:0]}
  localparam int unsigned c_cmd_rd      = 7;
  localparam int unsigned c_cmd_inc     = 6;
  localparam int unsigned c_cmd_ahi_msb = 5;

  // Read response substituted after the host overran a bus cycle
  localparam logic [7:0] c_overrun_fill = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single-bit level crossing into the
//            system clock domain; reset value selectable per instance.
// Revision : 1.0  initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] r_sync;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync <= {2{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[0], d_i};
    end
  end

  assign q_o = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/spi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_wb_bridge
// Purpose  : Decodes the command/address/data byte stream coming from the
//            SPI shift core and runs Wishbone classic cycles in the system
//            clock domain; read data is returned as the next MISO byte.
// Revision : 1.0  initial release
// ============================================================================
module spi_wb_bridge
  import spi_wb_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH = 17
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic                     spi_cs_ni,
  input  logic [7:0]               spi_data_i,
  input  logic                     spi_cycle_i,
  output logic [7:0]               spi_data_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [7:0]               wb_dat_o,
  input  logic [7:0]               wb_dat_i,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i
);

  localparam int unsigned c_hi_w = WB_ADDR_WIDTH - 16;
  localparam logic [WB_ADDR_WIDTH-1:0] c_addr_one = {{(WB_ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Synchronized SCK-domain controls
  logic w_cycle_s;
  logic w_cs_s;

  sync2 #(.RESET_VAL(1'b0)) u_sync_cycle (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .d_i      (spi_cycle_i),
    .q_o      (w_cycle_s)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .d_i      (spi_cs_ni),
    .q_o      (w_cs_s)
  );

  // Byte capture
  logic       r_cycle_d;
  logic       r_evt;
  logic [7:0] r_byte;
  logic       w_evt;
  logic       w_fsm_evt;

  // A byte is taken on the rising edge of the synchronized strobe; the data
  // bus has been stable for several clocks by then given the clock ratio.
  assign w_evt     = w_cycle_s & ~r_cycle_d & ~w_cs_s;
  assign w_fsm_evt = r_evt & ~w_cs_s;

  // Edge-detect the strobe and register the received byte with it
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cycle_d <= 1'b0;
      r_evt     <= 1'b0;
      r_byte    <= 8'h00;
    end else begin
      r_cycle_d <= w_cycle_s;
      r_evt     <= w_evt;
      if (w_evt) begin
        r_byte <= spi_data_i;
      end
    end
  end

  // High address bits carried by the command byte
  logic [c_hi_w-1:0] w_cmd_hi;

  generate
    if (c_hi_w <= c_cmd_ahi_msb + 1) begin : g_hi_narrow
      assign w_cmd_hi = r_byte[c_hi_w-1:0];
    end else begin : g_hi_wide
      assign w_cmd_hi = {{(c_hi_w - c_cmd_ahi_msb - 1){1'b0}}, r_byte[c_cmd_ahi_msb:0]};
    end
  endgenerate

  // FSM state and datapath registers
  state_t                   r_state, w_state_nxt;
  logic [WB_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                     r_rd, w_rd_nxt;
  logic                     r_inc, w_inc_nxt;
  logic                     r_overrun, w_ovr_nxt;
  logic                     r_cyc, w_cyc_nxt;
  logic                     r_we, w_we_nxt;
  logic [7:0]               r_wdat, w_wdat_nxt;
  logic [7:0]               r_miso, w_miso_nxt;

  // Register the decoder state together with every bus-facing output
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= ST_CMD;
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_inc     <= 1'b0;
      r_overrun <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_wdat    <= 8'h00;
      r_miso    <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rd      <= w_rd_nxt;
      r_inc     <= w_inc_nxt;
      r_overrun <= w_ovr_nxt;
      r_cyc     <= w_cyc_nxt;
      r_we      <= w_we_nxt;
      r_wdat    <= w_wdat_nxt;
      r_miso    <= w_miso_nxt;
    end
  end

  // Next-state and datapath decode for the frame protocol
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rd_nxt    = r_rd;
    w_inc_nxt   = r_inc;
    w_ovr_nxt   = r_overrun;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_wdat_nxt  = r_wdat;
    w_miso_nxt  = r_miso;

    case (r_state)
      ST_CMD: begin
        if (w_fsm_evt) begin
          w_rd_nxt    = r_byte[c_cmd_rd];
          w_inc_nxt   = r_byte[c_cmd_inc];
          w_addr_nxt  = {w_cmd_hi, r_addr[15:0]};
          w_state_nxt = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (w_fsm_evt) begin
          w_addr_nxt[15:8] = r_byte;
          w_state_nxt      = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (w_fsm_evt) begin
          w_addr_nxt[7:0] = r_byte;
          if (r_rd) begin
            // Prefetch so the first data byte shifted out already has data
            w_cyc_nxt   = 1'b1;
            w_we_nxt    = 1'b0;
            w_state_nxt = ST_BUS;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_fsm_evt) begin
          w_cyc_nxt = 1'b1;
          if (!r_rd) begin
            w_we_nxt   = 1'b1;
            w_wdat_nxt = r_byte;
          end
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        // A byte landing mid-cycle is dropped; remember it for the response
        if (w_fsm_evt) begin
          w_ovr_nxt = 1'b1;
        end
        if (wb_ack_i) begin
          w_cyc_nxt = 1'b0;
          w_we_nxt  = 1'b0;
          if (r_rd) begin
            w_miso_nxt = (r_overrun || w_fsm_evt) ? c_overrun_fill : wb_dat_i;
          end
          if (r_inc) begin
            w_addr_nxt = r_addr + c_addr_one;
          end
          w_state_nxt = w_cs_s ? ST_CMD : ST_DATA;
        end
      end
      default: begin
        w_state_nxt = ST_CMD;
      end
    endcase

    // Deselect ends the frame, but an outstanding bus cycle must see its ack
    if (w_cs_s) begin
      w_ovr_nxt = 1'b0;
      if (r_state != ST_BUS) begin
        w_state_nxt = ST_CMD;
      end
    end
  end

  assign spi_data_o = r_miso;
  assign wb_adr_o   = r_addr;
  assign wb_dat_o   = r_wdat;
  assign wb_we_o    = r_we;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_wb_bridge
// Purpose  : Self-checking bench for spi_wb_bridge: emulates the SPI shift
//            core and a Wishbone memory slave, predicts bus traffic and MISO
//            bytes from the frame rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_wb_bridge;

  localparam int AW   = 17;
  localparam int AMAX = 1 << AW;

  logic          clock_i     = 1'b0;
  logic          reset_ni    = 1'b0;
  logic          spi_cs_ni   = 1'b1;
  logic [7:0]    spi_data_i  = 8'h00;
  logic          spi_cycle_i = 1'b0;
  logic [7:0]    spi_data_o;
  logic [AW-1:0] wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic [7:0]    wb_dat_i    = 8'h00;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i    = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]    tx_q[$];
  logic [7:0]    rx_q[$];
  logic [AW-1:0] wr_adr_q[$];
  logic [7:0]    wr_dat_q[$];
  logic [AW-1:0] rd_adr_q[$];
  logic [7:0]    mem[int];
  logic [7:0]    ref_mem[int];

  int ack_delay = 0;
  int wait_cnt  = 0;
  int last_lat  = -1;
  int stb_drop  = 0;
  logic p_stb = 1'b0;
  logic p_ack = 1'b0;

  spi_wb_bridge #(.WB_ADDR_WIDTH(AW)) dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .spi_cs_ni   (spi_cs_ni),
    .spi_data_i  (spi_data_i),
    .spi_cycle_i (spi_cycle_i),
    .spi_data_o  (spi_data_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clock_i = ~clock_i;

  // Wishbone memory slave with programmable ack latency
  always @(posedge clock_i) begin
    wb_ack_i <= 1'b0;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack_i <= 1'b1;
        wait_cnt <= 0;
        if (wb_we_o) begin
          mem[int'(wb_adr_o)] = wb_dat_o;
          wr_adr_q.push_back(wb_adr_o);
          wr_dat_q.push_back(wb_dat_o);
        end else begin
          wb_dat_i <= mem.exists(int'(wb_adr_o)) ? mem[int'(wb_adr_o)] : 8'h00;
          rd_adr_q.push_back(wb_adr_o);
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Strobe must never fall without an ack in the previous cycle
  always @(negedge clock_i) begin
    if (p_stb && !p_ack && !wb_stb_o && reset_ni) stb_drop = stb_drop + 1;
    p_stb = wb_stb_o;
    p_ack = wb_ack_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mk_cmd(input logic rd, input logic inc, input logic [AW-1:0] a);
    mk_cmd = {rd, inc, 5'b00000, a[16]};
  endfunction

  // One SCK byte: strobe high one SCK period (8 clocks), then low 8 clocks;
  // MISO is captured one SCK period after the strobe rises.
  task automatic send_byte(input logic [7:0] b);
    last_lat = -1;
    @(negedge clock_i);
    spi_data_i  = b;
    spi_cycle_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock_i);
      if (wb_stb_o && last_lat < 0) last_lat = i;
    end
    rx_q.push_back(spi_data_o);
    spi_cycle_i = 1'b0;
    repeat (7) @(negedge clock_i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (wb_cyc_o && n < 200) begin
      @(negedge clock_i);
      n++;
    end
    n_cmp++;
    if (wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_idle_timeout: cyc=%b after %0d clocks, want 0", wb_cyc_o, n);
    end
  endtask

  task automatic send_frame();
    rx_q.delete();
    @(negedge clock_i);
    spi_cs_ni = 1'b0;
    repeat (4) @(negedge clock_i);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    wait_idle();
    spi_cs_ni = 1'b1;
    repeat (6) @(negedge clock_i);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_ni = 1'b1;
    repeat (2) @(negedge clock_i);
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: cyc/stb/we=%b want 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, spi_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: adr=%h dat=%h miso=%h want all 0", wb_adr_o, wb_dat_o, spi_data_o);
    end
  endtask

  task automatic test_write();
    for (int it = 0; it < 5; it++) begin
      logic [AW-1:0] a;
      logic          inc;
      int            n;
      logic [7:0]    d;
      logic [AW-1:0] ea[$];
      logic [7:0]    ed[$];
      if (it == 0) begin
        a = 17'h08000; inc = 1'b1; n = 2;
      end else begin
        a = AW'($urandom_range(0, AMAX - 1));
        inc = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 4);
      end
      tx_q.delete();
      tx_q.push_back(mk_cmd(1'b0, inc, a));
      tx_q.push_back(a[15:8]);
      tx_q.push_back(a[7:0]);
      for (int k = 0; k < n; k++) begin
        d = (it == 0) ? ((k == 0) ? 8'hAA : 8'h55) : 8'($urandom);
        tx_q.push_back(d);
        ea.push_back(inc ? AW'(a + AW'(k)) : a);
        ed.push_back(d);
        ref_mem[int'(ea[k])] = d;
      end
      wr_adr_q.delete();
      wr_dat_q.delete();
      send_frame();
      if (it == 0) begin
        n_cmp++;
        if (last_lat !== 4) begin
          n_fail++;
          $display("FAIL write_stb_latency: %0d clocks, want 4", last_lat);
        end
      end
      n_cmp++;
      if (wr_adr_q.size() !== n) begin
        n_fail++;
        $display("FAIL write_count it%0d: %0d cycles, want %0d", it, wr_adr_q.size(), n);
      end
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (k >= wr_adr_q.size() || wr_adr_q[k] !== ea[k] || wr_dat_q[k] !== ed[k]) begin
          n_fail++;
          $display("FAIL write_beat it%0d k%0d: got %h@%h, want %h@%h", it, k,
                   (k < wr_dat_q.size()) ? wr_dat_q[k] : 8'hxx,
                   (k < wr_adr_q.size()) ? wr_adr_q[k] : {AW{1'bx}}, ed[k], ea[k]);
        end
      end
    end
  endtask

  task automatic test_read();
    for (int it = 0; it < 6; it++) begin
      logic [AW-1:0] a;
      logic          inc;
      int            n;
      logic [AW-1:0] ea[$];
      if (it == 0) begin
        a = 17'h1FFFF; inc = 1'b1; n = 2;
      end else if (it == 1) begin
        a = 17'h00010; inc = 1'b0; n = 3;
      end else begin
        a = AW'($urandom_range(0, AMAX - 1));
        inc = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 3);
      end
      for (int k = 0; k <= n; k++) begin
        logic [7:0] v;
        ea.push_back(inc ? AW'(a + AW'(k)) : a);
        v = 8'($urandom);
        if (it == 0 && k == 0) v = 8'h12;
        if (it == 0 && k == 1) v = 8'h34;
        if (!(it == 1 && k > 0)) begin
          mem[int'(ea[k])]     = v;
          ref_mem[int'(ea[k])] = v;
        end
      end
      tx_q.delete();
      tx_q.push_back(mk_cmd(1'b1, inc, a));
      tx_q.push_back(a[15:8]);
      tx_q.push_back(a[7:0]);
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      rd_adr_q.delete();
      send_frame();
      n_cmp++;
      if (rd_adr_q.size() !== n + 1) begin
        n_fail++;
        $display("FAIL read_count it%0d: %0d cycles, want %0d", it, rd_adr_q.size(), n + 1);
      end
      for (int k = 0; k <= n; k++) begin
        n_cmp++;
        if (k >= rd_adr_q.size() || rd_adr_q[k] !== ea[k]) begin
          n_fail++;
          $display("FAIL read_addr it%0d k%0d: got %h want %h", it, k,
                   (k < rd_adr_q.size()) ? rd_adr_q[k] : {AW{1'bx}}, ea[k]);
        end
        n_cmp++;
        if (rx_q[2 + k] !== ref_mem[int'(ea[k])]) begin
          n_fail++;
          $display("FAIL read_miso it%0d k%0d: got %h want %h", it, k, rx_q[2 + k], ref_mem[int'(ea[k])]);
        end
      end
    end
  endtask

  task automatic test_cs_abort();
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [7:0]    d;
    int            n = 0;
    a = AW'($urandom_range(0, AMAX - 1));
    d = 8'($urandom);
    stb_drop  = 0;
    ack_delay = 6;
    wr_adr_q.delete();
    wr_dat_q.delete();
    @(negedge clock_i);
    spi_cs_ni = 1'b0;
    repeat (4) @(negedge clock_i);
    send_byte(mk_cmd(1'b0, 1'b0, a));
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    @(negedge clock_i);
    spi_data_i  = d;
    spi_cycle_i = 1'b1;
    while (!wb_stb_o && n < 12) begin
      @(negedge clock_i);
      n++;
    end
    n_cmp++;
    if (wb_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_stb_start: stb=%b want 1", wb_stb_o);
    end
    spi_cs_ni = 1'b1;
    repeat (3) @(negedge clock_i);
    n_cmp++;
    if (wb_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_stb_held: stb=%b before ack, want 1", wb_stb_o);
    end
    wait_idle();
    ref_mem[int'(a)] = d;
    n_cmp++;
    if (wr_adr_q.size() !== 1 || wr_adr_q[0] !== a || wr_dat_q[0] !== d) begin
      n_fail++;
      $display("FAIL abort_write: %0d cycles first %h@%h, want 1 cycle %h@%h", wr_adr_q.size(),
               (wr_dat_q.size() > 0) ? wr_dat_q[0] : 8'hxx,
               (wr_adr_q.size() > 0) ? wr_adr_q[0] : {AW{1'bx}}, d, a);
    end
    n_cmp++;
    if (stb_drop !== 0) begin
      n_fail++;
      $display("FAIL abort_stb_drop: %0d drops without ack, want 0", stb_drop);
    end
    spi_cycle_i = 1'b0;
    repeat (8) @(negedge clock_i);
    ack_delay = 0;
    b = AW'($urandom_range(0, AMAX - 1));
    mem[int'(b)]     = 8'($urandom);
    ref_mem[int'(b)] = mem[int'(b)];
    tx_q = '{mk_cmd(1'b1, 1'b0, b), b[15:8], b[7:0], 8'h00};
    send_frame();
    n_cmp++;
    if (rx_q[2] !== ref_mem[int'(b)]) begin
      n_fail++;
      $display("FAIL abort_next_frame: miso %h want %h", rx_q[2], ref_mem[int'(b)]);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, AMAX - 1));
    @(negedge clock_i);
    spi_cs_ni = 1'b0;
    repeat (4) @(negedge clock_i);
    rx_q.delete();
    send_byte(8'h81);
    send_byte(8'h5A);
    @(negedge clock_i);
    #2 reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_ctrl: cyc/stb/we=%b want 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, spi_data_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: adr=%h dat=%h miso=%h want all 0", wb_adr_o, wb_dat_o, spi_data_o);
    end
    repeat (2) @(negedge clock_i);
    reset_ni = 1'b1;
    repeat (4) @(negedge clock_i);
    mem[int'(a)]     = 8'($urandom);
    ref_mem[int'(a)] = mem[int'(a)];
    rd_adr_q.delete();
    rx_q.delete();
    send_byte(mk_cmd(1'b1, 1'b0, a));
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'h00);
    wait_idle();
    spi_cs_ni = 1'b1;
    repeat (6) @(negedge clock_i);
    n_cmp++;
    if (rd_adr_q.size() !== 2 || rd_adr_q[0] !== a) begin
      n_fail++;
      $display("FAIL midreset_reads: %0d cycles first @%h, want 2 @%h", rd_adr_q.size(),
               (rd_adr_q.size() > 0) ? rd_adr_q[0] : {AW{1'bx}}, a);
    end
    n_cmp++;
    if (rx_q[2] !== ref_mem[int'(a)]) begin
      n_fail++;
      $display("FAIL midreset_miso: got %h want %h", rx_q[2], ref_mem[int'(a)]);
    end
  endtask

  task automatic test_overrun();
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] b1;
    a = AW'($urandom_range(0, AMAX - 1));
    mem[int'(a)]     = 8'($urandom_range(0, 254));
    ref_mem[int'(a)] = mem[int'(a)];
    ack_delay = 20;
    rd_adr_q.delete();
    @(negedge clock_i);
    spi_cs_ni = 1'b0;
    repeat (4) @(negedge clock_i);
    send_byte(mk_cmd(1'b1, 1'b0, a));
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'h00);
    wait_idle();
    n_cmp++;
    if (rd_adr_q.size() !== 1) begin
      n_fail++;
      $display("FAIL overrun_dropped: %0d cycles, want 1", rd_adr_q.size());
    end
    n_cmp++;
    if (spi_data_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL overrun_fill: miso %h want ff", spi_data_o);
    end
    spi_cs_ni = 1'b1;
    repeat (6) @(negedge clock_i);
    ack_delay = 0;
    b  = AW'($urandom_range(0, AMAX - 1));
    b1 = AW'(b + AW'(1));
    mem[int'(b)]      = 8'($urandom_range(0, 254));
    mem[int'(b1)]     = 8'($urandom_range(0, 254));
    ref_mem[int'(b)]  = mem[int'(b)];
    ref_mem[int'(b1)] = mem[int'(b1)];
    tx_q = '{mk_cmd(1'b1, 1'b1, b), b[15:8], b[7:0], 8'h00};
    send_frame();
    n_cmp++;
    if (rx_q[2] !== ref_mem[int'(b)] || rx_q[3] !== ref_mem[int'(b1)]) begin
      n_fail++;
      $display("FAIL overrun_cleared: miso %h %h want %h %h", rx_q[2], rx_q[3],
               ref_mem[int'(b)], ref_mem[int'(b1)]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_cs_abort();
    test_reset_mid();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
